// File: rtl/sample_block_framer.sv
// Ping-pong block collector for the FFT path.
// Blocks leave as Avalon-ST packets, optionally zero-padded to twice their length.
module sample_block_framer #(
  parameter int DATA_W    = 16,
  parameter int BLOCK_LEN = 64,
  parameter int ZERO_PAD  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              overflow,
  output logic [15:0]       drop_count,
  input  logic              clear_overflow
);

  localparam int AW = $clog2(BLOCK_LEN);
  localparam logic [AW-1:0] WLAST = AW'(BLOCK_LEN - 1);
  localparam logic [AW:0]   LAST  = (AW+1)'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_REL
  } state_t;

  logic [DATA_W-1:0] mem [2*BLOCK_LEN];

  logic          wb, rb;
  logic [AW-1:0] wp;
  logic [1:0]    full;
  logic [AW:0]   cnt, cnt_nxt;
  state_t        state, state_nxt;

  logic rel, wr_ok, wr_en, drop, issue, eop_acc;

  // A bank released this cycle is already free for the writer
  assign rel     = (state == S_REL);
  assign wr_ok   = !full[wb] || (rel && (rb == wb));
  assign wr_en   = in_valid && wr_ok;
  assign drop    = in_valid && !wr_ok;
  assign issue   = ((state == S_DATA) || (state == S_PAD))
                   && !cnt[AW] && (!out_valid || out_ready);
  assign eop_acc = out_valid && out_ready && out_eop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wp}] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb   <= 1'b0;
      wp   <= '0;
      full <= '0;
    end else begin
      if (rel) full[rb] <= 1'b0;
      if (wr_en) begin
        if (wp == WLAST) begin
          full[wb] <= 1'b1;
          wp       <= '0;
          wb       <= ~wb;
        end else begin
          wp <= wp + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      rb    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rel) rb <= ~rb;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (full[rb]) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (issue) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST && ZERO_PAD != 0) begin
            state_nxt = S_PAD;
            cnt_nxt   = '0;
          end
        end else if (cnt[AW] && eop_acc) begin
          state_nxt = S_REL;
        end
      end
      S_PAD: begin
        if (issue) begin
          cnt_nxt = cnt + 1'b1;
        end else if (cnt[AW] && eop_acc) begin
          state_nxt = S_REL;
        end
      end
      S_REL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register doubles as the registered memory read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= (state == S_DATA) ? mem[{rb, cnt[AW-1:0]}] : '0;
      out_sop   <= (state == S_DATA) && (cnt == '0);
      out_eop   <= (state == S_PAD) ? (cnt == LAST)
                   : ((ZERO_PAD == 0) && (cnt == LAST));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
